// File: rtl/pattern_detector_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package pattern_detector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

  localparam int unsigned PAT_LEN_MIN = 1;
  localparam int unsigned PAT_LEN_MAX = 16;

  localparam state_t RST_STATE   = IDLE;
  localparam logic   RST_FOUND   = 1'b0;
  localparam logic   RST_ARMED   = 1'b0;
  localparam logic   RST_OVERLAP = 1'b0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX_VAL = {W{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && (value != MAX_VAL)) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/pattern_detector_param.sv
// Serial pattern detector: matches the last PAT_LEN valid bits against a
// runtime-loaded pattern, with overlapping or non-overlapping match modes.
module pattern_detector_param
  import pattern_detector_pkg::*;
#(
  parameter int unsigned PAT_LEN = 5,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cfg_load,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               count_clr,
  output logic               found,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam int unsigned      FILL_W    = $clog2(PAT_LEN + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);

  generate
    if ((PAT_LEN < PAT_LEN_MIN) || (PAT_LEN > PAT_LEN_MAX)) begin : g_bad_pat_len
      $error("pattern_detector_param: PAT_LEN must be within 1..16");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [PAT_LEN-1:0] hist_q, hist_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               armed_d;
  logic               match_c;
  logic [PAT_LEN-1:0] win_c;
  logic [FILL_W-1:0]  fill_upd_c;

  // Next-state, history and match decode; a load always discards the bit.
  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    pat_d      = pat_q;
    fill_d     = fill_q;
    ovl_d      = ovl_q;
    armed_d    = armed;
    match_c    = 1'b0;
    win_c      = PAT_LEN'({hist_q, in});
    fill_upd_c = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FILL_W'(1);

    if (cfg_load) begin
      state_d = FILL;
      hist_d  = '0;
      fill_d  = '0;
      pat_d   = cfg_pattern;
      ovl_d   = cfg_overlap;
      armed_d = 1'b1;
    end else if (in_valid) begin
      case (state_q)
        FILL, HUNT: begin
          hist_d  = win_c;
          fill_d  = fill_upd_c;
          state_d = (fill_upd_c == FILL_FULL) ? HUNT : FILL;
          if ((fill_upd_c == FILL_FULL) && (win_c == pat_q)) begin
            match_c = 1'b1;
            if (!ovl_q) begin
              hist_d  = '0;
              fill_d  = '0;
              state_d = FILL;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      hist_q  <= '0;
      pat_q   <= '0;
      fill_q  <= '0;
      ovl_q   <= RST_OVERLAP;
      armed   <= RST_ARMED;
      found   <= RST_FOUND;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      fill_q  <= fill_d;
      ovl_q   <= ovl_d;
      armed   <= armed_d;
      found   <= match_c;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match_c),
    .clr   (count_clr),
    .value (match_count)
  );

endmodule

// File: tb/tb_pattern_detector_param.sv
// Scoreboard bench: four detector configurations share one stimulus stream.
module tb_pattern_detector_param;

  localparam int ND = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_bit, cfg_load, cfg_overlap, count_clr;
  logic [4:0] pat_a, pat_c;
  logic [3:0] pat_b;
  logic [0:0] pat_d;
  logic [4:0] np_a, np_c;
  logic [3:0] np_b;
  logic [0:0] np_d;
  logic       n_ovl;
  logic [ND-1:0] found, armed;
  logic [7:0] cnt_a, cnt_b, cnt_d;
  logic [1:0] cnt_c;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pattern_detector_param #(.PAT_LEN(5), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(pat_a), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .found(found[0]), .match_count(cnt_a), .armed(armed[0]));
  pattern_detector_param #(.PAT_LEN(4), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(pat_b), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .found(found[1]), .match_count(cnt_b), .armed(armed[1]));
  pattern_detector_param #(.PAT_LEN(5), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(pat_c), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .found(found[2]), .match_count(cnt_c), .armed(armed[2]));
  pattern_detector_param #(.PAT_LEN(1), .CNT_W(8)) dut_d (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in(in_bit), .cfg_load(cfg_load),
    .cfg_pattern(pat_d), .cfg_overlap(cfg_overlap), .count_clr(count_clr),
    .found(found[3]), .match_count(cnt_d), .armed(armed[3]));

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  int   plen[ND] = '{5, 4, 5, 1};
  int   cmax[ND] = '{255, 255, 3, 255};
  exp_t sb[ND][$];
  bit   hq[ND][$];
  int   m_pat[ND], m_cnt[ND];
  bit   m_arm[ND], m_ovl[ND];
  int   n_cmp = 0, n_bad = 0;
  exp_t mon_e;

  function automatic int dut_cnt(int d);
    case (d)
      0: return int'(cnt_a);
      1: return int'(cnt_b);
      2: return int'(cnt_c);
      default: return int'(cnt_d);
    endcase
  endfunction

  function automatic int dut_pat(int d);
    case (d)
      0: return int'(pat_a);
      1: return int'(pat_b);
      2: return int'(pat_c);
      default: return int'(pat_d);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: window = last plen accepted bits, oldest bit is pattern MSB.
  task automatic model_step(bit r, bit v, bit b, bit ld, bit clr);
    bit   m;
    int   w;
    exp_t e;
    for (int d = 0; d < ND; d++) begin
      m = 1'b0;
      w = 0;
      if (r) begin
        m_arm[d] = 1'b0; m_cnt[d] = 0; m_pat[d] = 0; m_ovl[d] = 1'b0;
        hq[d].delete();
        continue;
      end
      if (ld) begin
        m_arm[d] = 1'b1;
        m_pat[d] = dut_pat(d);
        m_ovl[d] = cfg_overlap;
        hq[d].delete();
      end else if (v && m_arm[d]) begin
        hq[d].push_back(b);
        if (hq[d].size() > plen[d]) void'(hq[d].pop_front());
        if (hq[d].size() == plen[d]) begin
          for (int i = 0; i < hq[d].size(); i++) w = (w << 1) | int'(hq[d][i]);
          if (w == m_pat[d]) begin
            m = 1'b1;
            if (!m_ovl[d]) hq[d].delete();
          end
        end
      end
      if (clr) m_cnt[d] = 0;
      else if (m && (m_cnt[d] < cmax[d])) m_cnt[d]++;
      if (m) begin
        e.cyc = cyc + 1;
        e.cnt = m_cnt[d];
        sb[d].push_back(e);
      end
    end
  endtask

  task automatic drive(bit r, bit v, bit b, bit ld, bit clr);
    @(negedge clk);
    rst = r; in_valid = v; in_bit = b; cfg_load = ld; count_clr = clr;
    pat_a = np_a; pat_b = np_b; pat_c = np_c; pat_d = np_d; cfg_overlap = n_ovl;
    model_step(r, v, b, ld, clr);
  endtask

  task automatic checkpoint(string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s count dut%0d", tag, d), dut_cnt(d), m_cnt[d]);
      check($sformatf("%s armed dut%0d", tag, d), int'(armed[d]), int'(m_arm[d]));
    end
  endtask

  task automatic set_cfg(logic [4:0] a, logic [3:0] b, logic [4:0] c, logic d, logic ovl);
    np_a = a; np_b = b; np_c = c; np_d = d; n_ovl = ovl;
  endtask

  task automatic feed(logic [15:0] bits, int n);
    for (int i = n - 1; i >= 0; i--) drive(1'b0, 1'b1, bits[i], 1'b0, 1'b0);
  endtask

  // Monitor: every found pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      while ((sb[d].size() > 0) && (sb[d][0].cyc < cyc)) begin
        check($sformatf("found_missing dut%0d @%0d", d, sb[d][0].cyc), 0, 1);
        void'(sb[d].pop_front());
      end
      if (found[d]) begin
        if (sb[d].size() == 0) begin
          check($sformatf("found_spurious dut%0d", d), 1, 0);
        end else begin
          mon_e = sb[d].pop_front();
          check($sformatf("found_cycle dut%0d", d), cyc, mon_e.cyc);
          check($sformatf("found_count dut%0d", d), dut_cnt(d), mon_e.cnt);
        end
      end
    end
  end

  logic [15:0] stim;
  logic        rr, ll;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0; cfg_load = 1'b0; count_clr = 1'b0;
    cfg_overlap = 1'b0; pat_a = '0; pat_b = '0; pat_c = '0; pat_d = '0;
    set_cfg(5'b00110, 4'b0101, 5'b11111, 1'b1, 1'b1);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkpoint("reset");

    // Unarmed: valid bits are discarded.
    for (int i = 0; i < 4; i++) feed(16'b00110, 5);
    checkpoint("idle");

    // Basic match.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b100110, 6);
    checkpoint("basic");

    // Overlap then non-overlap on 01010101.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b01010101, 8);
    checkpoint("overlap");
    set_cfg(5'b00110, 4'b0101, 5'b11111, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b01010101, 8);
    checkpoint("nonoverlap");

    // Gaps inside the pattern.
    set_cfg(5'b00110, 4'b0110, 5'b11111, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    stim = 16'b00110;
    for (int i = 4; i >= 0; i--) begin
      for (int g = 0; g < 1 + int'($urandom_range(0, 2)); g++)
        drive(1'b0, 1'b0, 1'($urandom), 1'b0, 1'b0);
      drive(1'b0, 1'b1, stim[i], 1'b0, 1'b0);
    end
    checkpoint("gaps");

    // Load coincident with the completing bit.
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b0011, 4);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    feed(16'b0011, 4);
    checkpoint("load_win");
    feed(16'b0, 1);
    checkpoint("after_load");

    // Saturation, then clear coincident with a match.
    set_cfg(5'b11111, 4'b1111, 5'b11111, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'hFF, 8);
    checkpoint("saturate");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkpoint("clr_match");
    feed(16'h3, 2);
    checkpoint("post_clr");

    // Reset mid-pattern.
    set_cfg(5'b00110, 4'b0110, 5'b00110, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b0011, 4);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkpoint("mid_reset");
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    feed(16'b0, 1);
    feed(16'b00110, 5);
    checkpoint("reload");

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 249) == 0);
      ll = ($urandom_range(0, 39) == 0);
      if (ll) set_cfg(5'($urandom), 4'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      drive(rr, ($urandom_range(0, 3) != 0), 1'($urandom), ll, ($urandom_range(0, 49) == 0));
    end
    checkpoint("random");

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) check($sformatf("sb_drain dut%0d", d), sb[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_detector_param.md
# pattern_detector_param

Parametrised serial pattern detector for single-bit streams. Compares the last PAT_LEN valid input bits against a runtime-loadable pattern and pulses `found` on each match. Selectable overlapping or non-overlapping match mode and a saturating match counter. Next-generation replacement for the fixed-pattern FSM recognisers in the sequential-logic block set.

## Interface
- PAT_LEN, 5, pattern length in bits; legal range 1..16.
- CNT_W, 8, width of the match counter.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  qualifies `in`; bits with in_valid=0 are ignored, and history is held.
- in  input  1  serial data bit.
- cfg_load  input  1  one-cycle strobe that latches cfg_pattern and cfg_overlap.
- cfg_pattern  input  PAT_LEN  pattern; bit PAT_LEN-1 is the first bit received.
- cfg_overlap  input  1  1 = overlapping matches, 0 = non-overlapping.
- count_clr  input  1  synchronous clear of match_count.
- found  output  1  one-cycle match pulse, registered.
- match_count  output  CNT_W  matches since reset/clear; saturates at all-ones.
- armed  output  1  high once a pattern has been loaded.

## Operation
- Internal state: hist[PAT_LEN-1:0] (newest bit in LSB), fill counter 0..PAT_LEN, latched pattern and overlap flag.
- FSM states:
  - IDLE: the state after reset. No pattern is loaded, found stays 0, and valid bits are discarded.
  - FILL: fewer than PAT_LEN bits are held.
  - HUNT: the window is full.
- Transitions:
  - cfg_load moves any state to FILL. It clears hist and fill, and sets armed=1.
  - In FILL, each valid bit increments fill. When fill reaches PAT_LEN, the state moves to HUNT.
  - HUNT stays in HUNT on each valid bit.
- Match: evaluated on a valid bit when the updated window {hist[PAT_LEN-2:0], in} equals the pattern and the updated fill equals PAT_LEN.
- After a match:
  - Overlap mode: state stays HUNT and history is kept.
  - Non-overlap mode: hist and fill are cleared and the state returns to FILL.
- match_count increments by 1 per match and saturates at 2^CNT_W-1 with no wrap.
- Priorities when events coincide:
  - rst overrides everything.
  - cfg_load with in_valid in the same cycle: load wins and the bit is discarded.
  - count_clr with a match in the same cycle: match_count becomes 0, and found still pulses.
- PAT_LEN=1: the window is just `in`. Every valid bit equal to cfg_pattern[0] matches. FILL lasts one bit.

## Timing
- Reset values:
  - found=0, match_count=0, armed=0.
  - State IDLE; hist, fill, pattern and overlap flag all 0.
- found rises in the cycle after the edge that samples the completing bit (latency 1). It is high for exactly one cycle per match.
- match_count updates on the same edge that raises found.
- Back-to-back matches in overlap mode can produce found on consecutive cycles (e.g. pattern all-ones).
- rst asserted mid-stream takes effect at the next edge. The pattern must be reloaded afterwards.
- in_valid low cycles are transparent: matches span gaps.

## Structure
- Shared package `pattern_detector_pkg` holds:
  - the state enum (IDLE, FILL, HUNT);
  - the PAT_LEN legality bounds (PAT_LEN_MIN=1, PAT_LEN_MAX=16);
  - the reset constants.
- Sub-module `sat_counter` (parameter W; inputs inc and clr with clr priority; output value) implements match_count. It is reusable by sibling blocks.
- Elaboration-time check rejects PAT_LEN outside 1..16.

## Test plan
- Reset/idle: after rst, drive 20 valid bits of 00110 repeated with no cfg_load -> found never asserts, match_count=0, armed=0.
- Basic match: PAT_LEN=5, load pattern 5'b00110 with overlap=1, feed 1,0,0,1,1,0 -> a single found pulse one cycle after the sixth bit, match_count=1.
- Overlap vs non-overlap: PAT_LEN=4, pattern 4'b0101, stream 01010101:
  - overlap=1 -> 3 pulses, match_count=3;
  - reload with overlap=0, same stream -> 2 pulses, match_count=5.
- Gaps and simultaneity:
  - Insert in_valid=0 cycles inside the pattern -> match still detected.
  - Assert cfg_load together with a completing bit -> no pulse, and fill restarts at 0.
- Saturation/clear:
  - CNT_W=2, pattern 5'b11111, overlap=1, 8 ones -> pulses on bits 5..8 and match_count holds at 3.
  - count_clr coincident with a match -> match_count=0 and found=1.
- Reset mid-pattern: after 4 of 5 pattern bits, pulse rst, reload the pattern, send the final bit -> no match. The full 5 bits then produce one pulse.
